// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, payload layouts and
// load-FSM encodings.
package mem_stage_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned ES_TO_MS_BUS_WD = 71;
  localparam int unsigned MS_TO_WS_BUS_WD = 70;
  localparam int unsigned MS_FWD_BUS_WD   = 39;

  // Position of load_op inside es_to_ms_bus, needed before the payload is registered.
  localparam int unsigned ES_LOAD_OP_BIT  = 38;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_WAIT = 2'd1;
  localparam logic [1:0] MS_HOLD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            load_op;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] alu_result;
  } es_to_ms_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] final_result;
  } ms_to_ws_t;

  typedef struct packed {
    logic            fwd_valid;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] fwd_data;
  } ms_fwd_t;

  // ID only trusts the bypass when fwd_valid is set, so keep every field quiet otherwise.
  function automatic logic [MS_FWD_BUS_WD-1:0] pack_fwd(input logic            valid,
                                                       input logic            we,
                                                       input logic [4:0]      waddr,
                                                       input logic [XLEN-1:0] data);
    ms_fwd_t fwd;
    fwd = '0;
    if (valid) begin
      fwd.fwd_valid = 1'b1;
      fwd.rf_we     = we;
      fwd.rf_waddr  = waddr;
      fwd.fwd_data  = data;
    end
    return fwd;
  endfunction

endpackage

// File: rtl/mem_load_buf.sv
// Load completion tracker: waits for the single-cycle data_ok pulse and parks the
// read data while WB is not accepting.
module mem_load_buf
  import mem_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ms_valid_i,
  input  logic            ws_allowin_i,
  input  logic            load_in_i,
  input  logic            data_ok_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic            ready_go_o,
  output logic [XLEN-1:0] load_data_o
);

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic            capture;
  logic [XLEN-1:0] rdata_buf_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      MS_IDLE: begin
        if (load_in_i) state_d = MS_WAIT;
      end
      MS_WAIT: begin
        // data_ok outside a waiting load is dropped; only WAIT reacts to it.
        if (ms_valid_i && data_ok_i) begin
          if (ws_allowin_i) begin
            state_d = load_in_i ? MS_WAIT : MS_IDLE;
          end else begin
            state_d = MS_HOLD;
            capture = 1'b1;
          end
        end
      end
      MS_HOLD: begin
        if (ws_allowin_i) state_d = load_in_i ? MS_WAIT : MS_IDLE;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  sirv_gnrl_dfflr #(
    .DW(2)
  ) u_state_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .lden_i(1'b1),
    .dnxt_i(state_d),
    .qout_o(state_q)
  );

  sirv_gnrl_dfflr #(
    .DW(XLEN)
  ) u_rdata_buf_dff (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .lden_i(capture),
    .dnxt_i(rdata_i),
    .qout_o(rdata_buf_q)
  );

  assign ready_go_o  = ((state_q == MS_WAIT) && data_ok_i) || (state_q == MS_HOLD);
  assign load_data_o = (state_q == MS_HOLD) ? rdata_buf_q : rdata_i;

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enable flop with synchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          lden_i,
  input  logic [DW-1:0] dnxt_i,
  output logic [DW-1:0] qout_o
);

  logic [DW-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (lden_i) begin
      q_q <= dnxt_i;
    end
  end

  assign qout_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX payload, completes variable-latency loads and
// feeds WB plus the ID bypass/stall path.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [XLEN-1:0]            data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
  output logic                       ms_load_stall
);

  logic                       ms_valid_q;
  logic [ES_TO_MS_BUS_WD-1:0] payload_q;
  es_to_ms_t                  ms_pl;
  ms_to_ws_t                  ws_pl;
  logic                       ms_ready_go;
  logic                       payload_en;
  logic                       load_in;
  logic                       ld_ready_go;
  logic [XLEN-1:0]            ld_data;
  logic [XLEN-1:0]            final_result;
  logic                       fwd_valid;

  assign payload_en = ms_allowin & es_to_ms_valid;
  assign load_in    = payload_en & es_to_ms_bus[ES_LOAD_OP_BIT];

  sirv_gnrl_dfflr #(
    .DW(1)
  ) u_valid_dff (
    .clk_i (clk),
    .rst_ni(reset),
    .lden_i(ms_allowin),
    .dnxt_i(es_to_ms_valid),
    .qout_o(ms_valid_q)
  );

  sirv_gnrl_dfflr #(
    .DW(ES_TO_MS_BUS_WD)
  ) u_payload_dff (
    .clk_i (clk),
    .rst_ni(reset),
    .lden_i(payload_en),
    .dnxt_i(es_to_ms_bus),
    .qout_o(payload_q)
  );

  assign ms_pl = payload_q;

  mem_load_buf u_load_buf (
    .clk_i       (clk),
    .rst_ni      (reset),
    .ms_valid_i  (ms_valid_q),
    .ws_allowin_i(ws_allowin),
    .load_in_i   (load_in),
    .data_ok_i   (data_sram_data_ok),
    .rdata_i     (data_sram_rdata),
    .ready_go_o  (ld_ready_go),
    .load_data_o (ld_data)
  );

  assign ms_ready_go    = ~ms_pl.load_op | ld_ready_go;
  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_load_stall  = ms_valid_q & ms_pl.load_op & ~ms_ready_go;

  assign final_result = ms_pl.load_op ? ld_data : ms_pl.alu_result;

  always_comb begin
    ws_pl              = '0;
    ws_pl.pc           = ms_pl.pc;
    ws_pl.rf_we        = ms_pl.rf_we;
    ws_pl.rf_waddr     = ms_pl.rf_waddr;
    ws_pl.final_result = final_result;
  end

  assign ms_to_ws_bus = ws_pl;

  // $0 is not filtered here; the register file side masks it.
  assign fwd_valid  = ms_valid_q & ms_pl.rf_we & ms_ready_go;
  assign ms_fwd_bus = pack_fwd(fwd_valid, ms_pl.rf_we, ms_pl.rf_waddr, final_result);

endmodule
